sdram_write_engine: RTL and testbench

SDRAM_WRITE_ENGINE -- requirements
Module: sdram_write_engine

---
 rtl/sdram_write_engine_if.sv | 24 ++
 rtl/sdram_write_engine.sv | 238 +++++++++++++++++++++++
 tb/tb_sdram_write_engine.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_write_engine_if.sv
// Upstream write-request and data-pop handshake between a controller and the SDRAM write engine.
interface sdram_write_engine_if;
  logic        write_en;
  logic [19:0] addr;
  logic        write_ack;
  logic        wr_data_req;
  logic [15:0] wr_data;

  modport master (
    output write_en,
    output addr,
    output wr_data,
    input  write_ack,
    input  wr_data_req
  );

  modport slave (
    input  write_en,
    input  addr,
    input  wr_data,
    output write_ack,
    output wr_data_req
  );
endinterface

// File: rtl/sdram_write_engine.sv
// Single-burst SDRAM write sequencer (ACTIVE/WRITE/PRECHARGE) with interleaved auto-refresh.
module sdram_write_engine #(
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned T_RCD      = 2,
  parameter int unsigned T_WR       = 2,
  parameter int unsigned T_RP       = 2,
  parameter int unsigned T_RFC      = 7,
  parameter int unsigned REF_CYCLES = 780
) (
  input  logic                 S_CLK,
  input  logic                 RST_N,
  input  logic                 init_done,
  sdram_write_engine_if.slave  up,
  output logic                 sdram_cs_n,
  output logic                 sdram_ras_n,
  output logic                 sdram_cas_n,
  output logic                 sdram_we_n,
  output logic [1:0]           sdram_ba,
  output logic [11:0]          sdram_a,
  output logic [15:0]          sdram_dq_out,
  output logic                 sdram_dq_oe,
  output logic [1:0]           sdram_dqm
);

  // Zero-valued timing parameters behave as one cycle.
  localparam int unsigned Bl     = (BURST_LEN == 0) ? 1 : ((BURST_LEN > 8) ? 8 : BURST_LEN);
  localparam int unsigned Trcd   = (T_RCD == 0) ? 1 : T_RCD;
  localparam int unsigned Twr    = (T_WR == 0) ? 1 : T_WR;
  localparam int unsigned Trp    = (T_RP == 0) ? 1 : T_RP;
  localparam int unsigned Trfc   = (T_RFC == 0) ? 1 : T_RFC;
  localparam int unsigned RefLen = (REF_CYCLES == 0) ? 1 : REF_CYCLES;
  localparam int unsigned RefW   = (RefLen > 1) ? $clog2(RefLen) : 1;

  localparam logic [RefW-1:0] RefMax  = RefW'(RefLen - 1);
  localparam logic [4:0]      RcdLoad = 5'((Trcd > 1) ? Trcd - 2 : 0);
  localparam logic [4:0]      WrLoad  = 5'(Bl + Twr - 2);
  localparam logic [4:0]      RpLoad  = 5'((Trp > 1) ? Trp - 2 : 0);
  localparam logic [4:0]      RfcLoad = 5'((Trfc > 1) ? Trfc - 2 : 0);
  localparam logic [2:0]      BlLoad  = 3'(Bl - 1);

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;

  typedef enum logic [3:0] {
    StIdle, StCapture, StAct, StRcdWait, StWrite, StWrWait,
    StPre, StRpWait, StAck, StRef, StRfcWait
  } state_e;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [1:0]        bank_q, bank_d;
  logic [7:0]        col_q, col_d;
  logic [RefW-1:0]   ref_cnt_q, ref_cnt_d;
  logic              ref_pend_q, ref_pend_d;
  logic              ack_blk_q, ack_blk_d;
  logic [2:0]        req_left_q, req_left_d;
  logic              req_q, req_d;
  logic              ack_q, ack_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [1:0]        ba_q, ba_d;
  logic [11:0]       a_q, a_d;
  logic [15:0]       dq_q, dq_d;
  logic              oe_q, oe_d;
  logic [1:0]        dqm_q, dqm_d;
  logic              pre_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // Refresh wins; a write_en lingering right after an ack is not a new request.
        if (init_done) begin
          if (ref_pend_q)                      state_d = StRef;
          else if (up.write_en && !ack_blk_q)  state_d = StCapture;
        end
      end
      StCapture: state_d = StAct;
      StAct: begin
        if (Trcd > 1) begin
          state_d = StRcdWait;
          cnt_d   = RcdLoad;
        end else begin
          state_d = StWrite;
        end
      end
      StRcdWait: begin
        if (cnt_q == '0) state_d = StWrite;
        else             cnt_d   = cnt_q - 5'd1;
      end
      StWrite: begin
        state_d = StWrWait;
        cnt_d   = WrLoad;
      end
      StWrWait: begin
        if (cnt_q == '0) state_d = StPre;
        else             cnt_d   = cnt_q - 5'd1;
      end
      StPre: begin
        if (Trp > 1) begin
          state_d = StRpWait;
          cnt_d   = RpLoad;
        end else begin
          state_d = StAck;
        end
      end
      StRpWait: begin
        if (cnt_q == '0) state_d = StAck;
        else             cnt_d   = cnt_q - 5'd1;
      end
      StAck: state_d = StIdle;
      StRef: begin
        if (Trfc > 1) begin
          state_d = StRfcWait;
          cnt_d   = RfcLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StRfcWait: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 5'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_d  = CmdNop;
    ba_d   = ba_q;
    a_d    = a_q;
    ack_d  = 1'b0;
    bank_d = bank_q;
    col_d  = col_q;
    if (state_q == StCapture) begin
      bank_d = up.addr[19:18];
      col_d  = up.addr[7:0];
    end
    unique case (state_d)
      StAct: begin
        cmd_d = CmdAct;
        ba_d  = up.addr[19:18];
        a_d   = {2'b00, up.addr[17:8]};
      end
      StWrite: begin
        cmd_d = CmdWr;
        ba_d  = bank_q;
        a_d   = {4'b0000, col_q};
      end
      StPre: begin
        cmd_d = CmdPre;
        ba_d  = bank_q;
        a_d   = '0;
      end
      StAck:   ack_d = 1'b1;
      StRef:   cmd_d = CmdRef;
      default: ;
    endcase
  end

  // Data pop starts one cycle ahead of WRITE so the word lands on DQ with the command.
  always_comb begin
    pre_write  = ((state_d == StAct) && (Trcd == 1)) ||
                 ((state_d == StRcdWait) && (cnt_d == '0));
    req_d      = 1'b0;
    req_left_d = req_left_q;
    if (pre_write) begin
      req_d      = 1'b1;
      req_left_d = BlLoad;
    end else if (req_left_q != '0) begin
      req_d      = 1'b1;
      req_left_d = req_left_q - 3'd1;
    end
    oe_d  = req_q;
    dqm_d = req_q ? 2'b00 : 2'b11;
    dq_d  = req_q ? up.wr_data : '0;
  end

  always_comb begin
    ref_cnt_d = '0;
    if (init_done) ref_cnt_d = (ref_cnt_q == RefMax) ? '0 : ref_cnt_q + RefW'(1);
    ref_pend_d = ref_pend_q;
    if (state_q == StRef) ref_pend_d = 1'b0;
    if (init_done && (ref_cnt_q == RefMax)) ref_pend_d = 1'b1;
    ack_blk_d = (state_q == StAck);
  end

  always_ff @(posedge S_CLK) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bank_q     <= '0;
      col_q      <= '0;
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ack_blk_q  <= 1'b0;
      req_left_q <= '0;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      cmd_q      <= CmdNop;
      ba_q       <= '0;
      a_q        <= '0;
      dq_q       <= '0;
      oe_q       <= 1'b0;
      dqm_q      <= 2'b11;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bank_q     <= bank_d;
      col_q      <= col_d;
      ref_cnt_q  <= ref_cnt_d;
      ref_pend_q <= ref_pend_d;
      ack_blk_q  <= ack_blk_d;
      req_left_q <= req_left_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      dq_q       <= dq_d;
      oe_q       <= oe_d;
      dqm_q      <= dqm_d;
    end
  end

  assign up.write_ack   = ack_q;
  assign up.wr_data_req = req_q;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
  assign sdram_ba     = ba_q;
  assign sdram_a      = a_q;
  assign sdram_dq_out = dq_q;
  assign sdram_dq_oe  = oe_q;
  assign sdram_dqm    = dqm_q;

endmodule

// File: tb/tb_sdram_write_engine.sv
// Scoreboard bench for sdram_write_engine: driver queues expected events, negedge monitor checks.
module tb_sdram_write_engine;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init_done = 1'b0;
  always #5 clk = ~clk;

  sdram_write_engine_if bus ();

  logic        cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [1:0]  ba, dqm;
  logic [11:0] a;
  logic [15:0] dq_out;
  logic [3:0]  cmd;
  assign cmd = {cs_n, ras_n, cas_n, we_n};

  sdram_write_engine #(.REF_CYCLES(20)) dut (
    .S_CLK       (clk),
    .RST_N       (rst_n),
    .init_done   (init_done),
    .up          (bus),
    .sdram_cs_n  (cs_n),
    .sdram_ras_n (ras_n),
    .sdram_cas_n (cas_n),
    .sdram_we_n  (we_n),
    .sdram_ba    (ba),
    .sdram_a     (a),
    .sdram_dq_out(dq_out),
    .sdram_dq_oe (dq_oe),
    .sdram_dqm   (dqm)
  );

  typedef struct {
    int          cyc;
    logic [3:0]  cmd;
    bit          chk;
    logic [1:0]  ba;
    logic [11:0] a;
  } cmd_t;
  typedef struct {
    int          cyc;
    logic [15:0] d;
  } dq_t;

  cmd_t exp_cmd[$];
  int   exp_req[$];
  dq_t  exp_dq[$];
  int   exp_ack[$];

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int widx    = 0;
  bit mon_en  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=0x%0h want=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_total++;
    n_bad++;
    $display("FAIL %s cycle=%0d got=0x%0h want=nothing", name, cyc, act);
  endtask

  // Monitor plus data source: supplies a word on each pop and queues it for the DQ check.
  always @(negedge clk) begin
    if (mon_en) begin
      if (cmd !== 4'b0111) begin
        if (exp_cmd.size() == 0) unexpected("cmd_unexpected", {28'd0, cmd});
        else begin
          cmd_t e;
          e = exp_cmd.pop_front();
          check("cmd_cycle", cyc, e.cyc);
          check("cmd_code", {28'd0, cmd}, {28'd0, e.cmd});
          if (e.chk) begin
            check("cmd_ba", {30'd0, ba}, {30'd0, e.ba});
            check("cmd_a", {20'd0, a}, {20'd0, e.a});
          end
        end
      end
      if (bus.wr_data_req !== 1'b0) begin
        logic [15:0] w;
        if (exp_req.size() == 0) unexpected("req_unexpected", cyc);
        else check("req_cycle", cyc, exp_req.pop_front());
        w = 16'h1111 * 16'(widx % 15 + 1);
        widx++;
        bus.wr_data = w;
        exp_dq.push_back('{cyc + 1, w});
      end else begin
        bus.wr_data = 16'h0;
      end
      if (dq_oe !== 1'b0) begin
        if (exp_dq.size() == 0) unexpected("dq_unexpected", {16'd0, dq_out});
        else begin
          dq_t d;
          d = exp_dq.pop_front();
          check("dq_cycle", cyc, d.cyc);
          check("dq_data", {16'd0, dq_out}, {16'd0, d.d});
          check("dqm_on", {30'd0, dqm}, 32'd0);
        end
      end else begin
        check("dqm_off", {30'd0, dqm}, 32'd3);
      end
      if (bus.write_ack !== 1'b0) begin
        if (exp_ack.size() == 0) unexpected("ack_unexpected", cyc);
        else check("ack_cycle", cyc, exp_ack.pop_front());
      end
    end
  end

  task automatic expect_write(input int t0, input logic [19:0] ad);
    exp_cmd.push_back('{t0 + 2, 4'b0011, 1'b1, ad[19:18], {2'b00, ad[17:8]}});
    exp_cmd.push_back('{t0 + 4, 4'b0100, 1'b1, ad[19:18], {4'b0000, ad[7:0]}});
    exp_cmd.push_back('{t0 + 10, 4'b0010, 1'b1, ad[19:18], 12'h000});
    for (int i = 0; i < 4; i++) exp_req.push_back(t0 + 3 + i);
    exp_ack.push_back(t0 + 12);
  endtask

  task automatic expect_ref(input int t);
    exp_cmd.push_back('{t, 4'b0001, 1'b0, 2'b00, 12'h000});
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    @(negedge clk);
    while (bus.write_ack !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (bus.write_ack !== 1'b1) unexpected("ack_timeout", cyc);
  endtask

  task automatic run_write(input logic [19:0] ad, input bit hold);
    init_done    = 1'b1;
    bus.write_en = 1'b1;
    bus.addr     = ad;
    expect_write(cyc, ad);
    wait_ack();
    if (hold) begin
      @(negedge clk);
      @(negedge clk);
    end
    bus.write_en = 1'b0;
    repeat (3) @(negedge clk);
    init_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int m, w, r;
    bus.write_en = 1'b0;
    bus.addr     = 20'h0;
    bus.wr_data  = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_cmd", {28'd0, cmd}, 32'h7);
    check("rst_ack", {31'd0, bus.write_ack}, 32'd0);
    check("rst_req", {31'd0, bus.wr_data_req}, 32'd0);
    check("rst_oe", {31'd0, dq_oe}, 32'd0);
    check("rst_dqm", {30'd0, dqm}, 32'd3);
    check("rst_ba", {30'd0, ba}, 32'd0);
    check("rst_a", {20'd0, a}, 32'd0);
    check("rst_dq", {16'd0, dq_out}, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    // Basic burst, with write_en left high one cycle past the ack.
    run_write(20'h4A3C5, 1'b1);

    // Idle refresh cadence.
    init_done = 1'b1;
    m = cyc;
    expect_ref(m + 21);
    expect_ref(m + 41);
    expect_ref(m + 61);
    repeat (70) @(negedge clk);
    init_done = 1'b0;
    repeat (2) @(negedge clk);

    // Refresh expiring mid-write must be served before the next ACTIVE.
    init_done = 1'b1;
    repeat (15) @(negedge clk);
    w = cyc;
    bus.write_en = 1'b1;
    bus.addr     = 20'hC7F12;
    expect_write(w, 20'hC7F12);
    expect_ref(w + 14);
    expect_write(w + 21, 20'h2055A);
    expect_ref(w + 35);
    wait_ack();
    @(negedge clk);
    bus.addr = 20'h2055A;
    wait_ack();
    bus.write_en = 1'b0;
    repeat (8) @(negedge clk);
    init_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a burst.
    r = cyc;
    init_done    = 1'b1;
    bus.write_en = 1'b1;
    bus.addr     = 20'h1ABCD;
    exp_cmd.push_back('{r + 2, 4'b0011, 1'b1, 2'b00, 12'h1AB});
    exp_cmd.push_back('{r + 4, 4'b0100, 1'b1, 2'b00, 12'h0CD});
    for (int i = 0; i < 4; i++) exp_req.push_back(r + 3 + i);
    repeat (6) @(negedge clk);
    rst_n        = 1'b0;
    bus.write_en = 1'b0;
    @(negedge clk);
    check("midrst_cmd", {28'd0, cmd}, 32'h7);
    check("midrst_oe", {31'd0, dq_oe}, 32'd0);
    check("midrst_ack", {31'd0, bus.write_ack}, 32'd0);
    check("midrst_req", {31'd0, bus.wr_data_req}, 32'd0);
    check("midrst_dq", {16'd0, dq_out}, 32'd0);
    init_done = 1'b0;
    @(negedge clk);
    check("midrst_ack2", {31'd0, bus.write_ack}, 32'd0);
    rst_n = 1'b1;
    #1 exp_dq.delete();
    @(negedge clk);
    run_write(20'h3FF01, 1'b0);

    // write_en held while init_done is low.
    bus.write_en = 1'b1;
    bus.addr     = 20'h0F00F;
    repeat (10) begin
      @(negedge clk);
      check("noinit_req", {31'd0, bus.wr_data_req}, 32'd0);
      check("noinit_cmd", {28'd0, cmd}, 32'h7);
    end
    init_done = 1'b1;
    expect_write(cyc, 20'h0F00F);
    wait_ack();
    bus.write_en = 1'b0;
    repeat (3) @(negedge clk);
    init_done = 1'b0;
    repeat (3) @(negedge clk);

    check("left_cmd", exp_cmd.size(), 32'd0);
    check("left_req", exp_req.size(), 32'd0);
    check("left_dq", exp_dq.size(), 32'd0);
    check("left_ack", exp_ack.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d got=running want=finished", cyc);
    $fatal(1);
  end
endmodule
